// File: rtl/vram_stroke_writer_if.sv
// vram_stroke_writer_if: bundles the touch-sample input side and the VRAM
// write-port output side of the stroke writer.
// master = stimulus/touch side, slave = stroke writer.
`timescale 1ns/1ps
interface vram_stroke_writer_if #(
    parameter int COORD_W = 9,
    parameter int ADDR_W  = 17
);
    logic               touch_valid;
    logic [COORD_W-1:0] touch_x;
    logic [COORD_W-1:0] touch_y;
    logic               clear_req;
    logic               vram_wr_ena;
    logic [ADDR_W-1:0]  vram_wr_addr;
    logic [15:0]        vram_wr_data;
    logic               busy;

    modport master (
        output touch_valid, touch_x, touch_y, clear_req,
        input  vram_wr_ena, vram_wr_addr, vram_wr_data, busy
    );

    modport slave (
        input  touch_valid, touch_x, touch_y, clear_req,
        output vram_wr_ena, vram_wr_addr, vram_wr_data, busy
    );
endinterface

// File: rtl/vram_stroke_writer.sv
// vram_stroke_writer: clears VRAM after reset or on request, then turns
// successive touch samples into continuous strokes by drawing a Bresenham
// line from the previous pen point to each new one, one VRAM write per cycle.
// Optional feature macro: COLOR_CYCLE_EN (pen colour cycles per stroke).
`timescale 1ns/1ps
module vram_stroke_writer #(
    parameter int          DISPLAY_WIDTH  = 240,
    parameter int          DISPLAY_HEIGHT = 320,
    parameter int          COORD_W        = 9,
    parameter int          ADDR_W         = 17,
    parameter logic [15:0] PEN_COLOR      = 16'hF800,
    parameter logic [15:0] BG_COLOR       = 16'h0000
) (
    input logic                 clk,
    input logic                 rst,
    vram_stroke_writer_if.slave bus
);
    localparam int                SW       = COORD_W + 2;
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(DISPLAY_WIDTH * DISPLAY_HEIGHT - 1);

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_TRACK, S_LINE} state_t;

    state_t               r_state;
    logic [ADDR_W-1:0]    r_clr_cnt;
    logic [COORD_W-1:0]   r_last_x, r_last_y;   // stroke endpoint (line target while drawing)
    logic [COORD_W-1:0]   r_cur_x, r_cur_y;     // Bresenham walking point
    logic signed [SW-1:0] r_dx, r_dy, r_err;
    logic                 r_sx_neg, r_sy_neg;
    logic                 r_clr_pend;

    logic                 w_in_range, w_same, w_pen_down;
    logic signed [SW-1:0] w_ddx, w_ddy, w_abs_dx, w_abs_dy;
    logic signed [SW-1:0] w_e2, w_nerr;
    logic                 w_step_x, w_step_y, w_line_done;
    logic [COORD_W-1:0]   w_nx, w_ny;
    logic [15:0]          w_down_color, w_line_color;

    function automatic logic [ADDR_W-1:0] pix_addr(input logic [COORD_W-1:0] x,
                                                   input logic [COORD_W-1:0] y);
        return ADDR_W'(y) * ADDR_W'(DISPLAY_WIDTH) + ADDR_W'(x);
    endfunction

    // Sample qualification, line setup deltas and one Bresenham step
    always_comb begin
        // NOTE: every signal driven here gets a value on every path, so no latch can be inferred.
        w_in_range  = (bus.touch_x < COORD_W'(DISPLAY_WIDTH)) &&
                      (bus.touch_y < COORD_W'(DISPLAY_HEIGHT));
        w_same      = (bus.touch_x == r_last_x) && (bus.touch_y == r_last_y);
        w_pen_down  = (r_state == S_IDLE) && !bus.clear_req && bus.touch_valid && w_in_range;

        w_ddx       = $signed({2'b00, bus.touch_x}) - $signed({2'b00, r_last_x});
        w_ddy       = $signed({2'b00, bus.touch_y}) - $signed({2'b00, r_last_y});
        w_abs_dx    = w_ddx[SW-1] ? -w_ddx : w_ddx;
        w_abs_dy    = w_ddy[SW-1] ? -w_ddy : w_ddy;

        w_e2        = r_err <<< 1;
        w_step_x    = (w_e2 >= r_dy);
        w_step_y    = (w_e2 <= r_dx);
        w_nerr      = r_err + (w_step_x ? r_dy : '0) + (w_step_y ? r_dx : '0);
        w_nx        = r_cur_x;
        w_ny        = r_cur_y;
        if (w_step_x) w_nx = r_sx_neg ? r_cur_x - COORD_W'(1) : r_cur_x + COORD_W'(1);
        if (w_step_y) w_ny = r_sy_neg ? r_cur_y - COORD_W'(1) : r_cur_y + COORD_W'(1);
        w_line_done = (w_nx == r_last_x) && (w_ny == r_last_y);
    end

`ifdef COLOR_CYCLE_EN
    logic [1:0]  r_color_idx;
    logic [15:0] r_stroke_color;

    function automatic logic [15:0] color_lut(input logic [1:0] idx);
        case (idx)
            2'd0:    return 16'hF800;
            2'd1:    return 16'h07E0;
            2'd2:    return 16'h001F;
            default: return 16'hFFFF;
        endcase
    endfunction

    assign w_down_color = color_lut(r_color_idx);
    assign w_line_color = r_stroke_color;

    // Latch the colour of each new stroke and advance the palette (clear keeps it)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_color_idx    <= 2'd0;
            r_stroke_color <= PEN_COLOR;
        end else if (w_pen_down) begin
            r_stroke_color <= w_down_color;
            r_color_idx    <= r_color_idx + 2'd1;
        end
    end
`else
    assign w_down_color = PEN_COLOR;
    assign w_line_color = PEN_COLOR;
`endif

    // Control FSM with registered VRAM write port and busy flag
    always_ff @(posedge clk) begin
        // NOTE: state and outputs use non-blocking assignments so every register updates from pre-edge values.
        if (rst) begin
            r_state          <= S_CLEAR;
            r_clr_cnt        <= '0;
            r_clr_pend       <= 1'b0;
            r_last_x         <= '0;
            r_last_y         <= '0;
            r_cur_x          <= '0;
            r_cur_y          <= '0;
            r_dx             <= '0;
            r_dy             <= '0;
            r_err            <= '0;
            r_sx_neg         <= 1'b0;
            r_sy_neg         <= 1'b0;
            bus.vram_wr_ena  <= 1'b0;
            bus.vram_wr_addr <= '0;
            bus.vram_wr_data <= '0;
            bus.busy         <= 1'b1;
        end else begin
            bus.vram_wr_ena <= 1'b0;
            bus.busy        <= (r_state == S_CLEAR) || (r_state == S_LINE);
            case (r_state)
                S_CLEAR: begin
                    bus.vram_wr_ena  <= 1'b1;
                    bus.vram_wr_addr <= r_clr_cnt;
                    bus.vram_wr_data <= BG_COLOR;
                    if (r_clr_cnt == LAST_PIX) begin
                        r_clr_cnt <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
                    end
                end
                S_IDLE: begin
                    if (bus.clear_req) begin
                        r_state <= S_CLEAR;
                    end else if (w_pen_down) begin
                        bus.vram_wr_ena  <= 1'b1;
                        bus.vram_wr_addr <= pix_addr(bus.touch_x, bus.touch_y);
                        bus.vram_wr_data <= w_down_color;
                        r_last_x         <= bus.touch_x;
                        r_last_y         <= bus.touch_y;
                        r_state          <= S_TRACK;
                    end
                end
                S_TRACK: begin
                    if (bus.clear_req) begin
                        r_state <= S_CLEAR;
                    end else if (!bus.touch_valid) begin
                        r_state <= S_IDLE;
                    end else if (w_in_range && !w_same) begin
                        // Walk from the old pen point; the new sample becomes the target
                        r_cur_x  <= r_last_x;
                        r_cur_y  <= r_last_y;
                        r_last_x <= bus.touch_x;
                        r_last_y <= bus.touch_y;
                        r_dx     <= w_abs_dx;
                        r_dy     <= -w_abs_dy;
                        r_err    <= w_abs_dx - w_abs_dy;
                        r_sx_neg <= w_ddx[SW-1];
                        r_sy_neg <= w_ddy[SW-1];
                        r_state  <= S_LINE;
                    end
                end
                S_LINE: begin
                    bus.vram_wr_ena  <= 1'b1;
                    bus.vram_wr_addr <= pix_addr(w_nx, w_ny);
                    bus.vram_wr_data <= w_line_color;
                    r_cur_x          <= w_nx;
                    r_cur_y          <= w_ny;
                    r_err            <= w_nerr;
                    if (w_line_done) begin
                        r_clr_pend <= 1'b0;
                        r_state    <= (r_clr_pend || bus.clear_req) ? S_CLEAR : S_TRACK;
                    end else if (bus.clear_req) begin
                        r_clr_pend <= 1'b1;
                    end
                end
                default: r_state <= S_CLEAR;
            endcase
        end
    end
endmodule

// File: tb/tb_vram_stroke_writer.sv
// tb_vram_stroke_writer: directed scenarios for vram_stroke_writer. A
// queue-based model lists every VRAM write the display should receive, in
// order; one compare process checks each DUT write against it. The display
// height is reduced so the three full clears stay short.
`timescale 1ns/1ps
module tb_vram_stroke_writer;
    localparam int          W   = 240;
    localparam int          H   = 64;
    localparam int          CW  = 9;
    localparam int          AW  = 17;
    localparam logic [15:0] PEN = 16'hF800;
    localparam logic [15:0] BG  = 16'h0000;

    typedef struct {
        int          addr;
        logic [15:0] data;
        logic        busy;
    } wr_t;

    logic clk;
    logic rst;
    wr_t  exp_q[$];
    int   line_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_writes = 0;

    vram_stroke_writer_if #(.COORD_W(CW), .ADDR_W(AW)) bus ();

    vram_stroke_writer #(
        .DISPLAY_WIDTH (W),
        .DISPLAY_HEIGHT(H),
        .COORD_W       (CW),
        .ADDR_W        (AW),
        .PEN_COLOR     (PEN),
        .BG_COLOR      (BG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int pix(input int x, input int y);
        return y * W + x;
    endfunction

    task automatic push_wr(input int addr, input logic [15:0] data, input logic busy);
        wr_t e;
        e.addr = addr;
        e.data = data;
        e.busy = busy;
        exp_q.push_back(e);
    endtask

    task automatic push_clear();
        for (int i = 0; i < W * H; i++) push_wr(i, BG, 1'b1);
    endtask

    // Reference line walk: every pixel after the start point, endpoint included
    task automatic build_line(input int x0, input int y0, input int x1, input int y1);
        int x, y, dx, dy, sx, sy, err, e2;
        line_q.delete();
        x   = x0;
        y   = y0;
        dx  = (x1 > x0) ? x1 - x0 : x0 - x1;
        dy  = (y1 > y0) ? y0 - y1 : y1 - y0;
        sx  = (x0 < x1) ? 1 : -1;
        sy  = (y0 < y1) ? 1 : -1;
        err = dx + dy;
        while (x != x1 || y != y1) begin
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
            line_q.push_back(pix(x, y));
        end
    endtask

    task automatic push_line();
        foreach (line_q[i]) push_wr(line_q[i], PEN, 1'b1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_touch(input logic v, input int x, input int y);
        // NOTE: stimulus uses blocking assignments away from the clock edge, so the DUT sees a stable value.
        bus.touch_valid = v;
        bus.touch_x     = CW'(x);
        bus.touch_y     = CW'(y);
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        check(name, exp_q.size(), 0);
    endtask

    // Compare every observed VRAM write against the model queue
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (bus.vram_wr_ena === 1'b1) begin
                n_writes++;
                check("write_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(bus.vram_wr_addr), e.addr);
                    check("wr_data", 32'(bus.vram_wr_data), 32'(e.data));
                    check("wr_busy", 32'(bus.busy), 32'(e.busy));
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        int n0;
        int found;
        int exp3[5] = '{1, 242, 243, 484, 485};

        clk = 1'b0;
        rst = 1'b1;
        bus.clear_req = 1'b0;
        set_touch(1'b0, 0, 0);

        // Scenario 1: reset state, then full clear
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wr_ena", 32'(bus.vram_wr_ena), 0);
        check("rst_wr_addr", 32'(bus.vram_wr_addr), 0);
        check("rst_wr_data", 32'(bus.vram_wr_data), 0);
        check("rst_busy", 32'(bus.busy), 1);
        push_clear();
        n0  = n_writes;
        rst = 1'b0;
        wait_drain("s1_clear_drain", W * H + 20);
        check("s1_clear_count", n_writes - n0, W * H);
        @(negedge clk);
        check("s1_idle_busy", 32'(bus.busy), 0);
        check("s1_idle_ena", 32'(bus.vram_wr_ena), 0);

        // Scenario 2: single tap at (10,20)
        n0 = n_writes;
        push_wr(4810, PEN, 1'b0);
        set_touch(1'b1, 10, 20);
        @(posedge clk);
        #1;
        set_touch(1'b0, 0, 0);
        @(negedge clk);
        check("s2_tap_ena", 32'(bus.vram_wr_ena), 1);
        check("s2_tap_addr", 32'(bus.vram_wr_addr), 4810);
        check("s2_tap_data", 32'(bus.vram_wr_data), 32'hF800);
        repeat (5) step();
        check("s2_write_count", n_writes - n0, 1);

        // Scenario 3: stroke (0,0) -> (5,2)
        n0 = n_writes;
        build_line(0, 0, 5, 2);
        check("s3_model_len", line_q.size(), 5);
        for (int i = 0; i < 5; i++) check("s3_model_addr", line_q[i], exp3[i]);
        push_wr(0, PEN, 1'b0);
        push_line();
        set_touch(1'b1, 0, 0);
        step();
        set_touch(1'b1, 5, 2);
        repeat (8) step();
        set_touch(1'b0, 0, 0);
        repeat (3) step();
        wait_drain("s3_drain", 5);
        check("s3_write_count", n_writes - n0, 6);

        // Scenario 4: out-of-range samples ignored, held sample written once
        n0 = n_writes;
        set_touch(1'b1, 240, 5);
        repeat (2) step();
        set_touch(1'b1, 3, H);
        repeat (2) step();
        set_touch(1'b0, 0, 0);
        repeat (2) step();
        check("s4_oob_writes", n_writes - n0, 0);
        push_wr(1687, PEN, 1'b0);
        set_touch(1'b1, 7, 7);
        repeat (10) step();
        set_touch(1'b0, 0, 0);
        repeat (3) step();
        wait_drain("s4_drain", 5);
        check("s4_hold_writes", n_writes - n0, 1);

        // Scenario 5: clear request in the middle of (0,0) -> (0,10)
        build_line(0, 0, 0, 10);
        check("s5_model_len", line_q.size(), 10);
        check("s5_model_first", line_q[0], 240);
        check("s5_model_last", line_q[9], 2400);
        push_wr(0, PEN, 1'b0);
        push_line();
        set_touch(1'b1, 0, 0);
        step();
        set_touch(1'b1, 0, 10);
        repeat (3) step();
        bus.clear_req = 1'b1;
        set_touch(1'b0, 0, 0);
        step();
        bus.clear_req = 1'b0;
        push_clear();
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clk);
            if (bus.vram_wr_ena === 1'b1 && bus.vram_wr_addr == AW'(2400)) found = 1;
        end
        check("s5_line_end_seen", found, 1);
        @(negedge clk);
        check("s5_clear_next_ena", 32'(bus.vram_wr_ena), 1);
        check("s5_clear_next_addr", 32'(bus.vram_wr_addr), 0);
        wait_drain("s5_clear_drain", W * H + 20);
        @(negedge clk);
        check("s5_idle_busy", 32'(bus.busy), 0);

        // Scenario 6: reset after two line pixels of (0,0) -> (5,2)
        push_wr(0, PEN, 1'b0);
        push_wr(1, PEN, 1'b1);
        push_wr(242, PEN, 1'b1);
        set_touch(1'b1, 0, 0);
        step();
        set_touch(1'b1, 5, 2);
        repeat (3) step();
        rst = 1'b1;
        set_touch(1'b0, 0, 0);
        push_clear();
        @(negedge clk);
        step();
        @(negedge clk);
        check("s6_abort_ena", 32'(bus.vram_wr_ena), 0);
        check("s6_abort_busy", 32'(bus.busy), 1);
        rst = 1'b0;
        @(negedge clk);
        check("s6_restart_ena", 32'(bus.vram_wr_ena), 1);
        check("s6_restart_addr", 32'(bus.vram_wr_addr), 0);
        wait_drain("s6_clear_drain", W * H + 20);
        @(negedge clk);
        check("s6_idle_busy", 32'(bus.busy), 0);
        check("s6_idle_ena", 32'(bus.vram_wr_ena), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
